// File: rtl/ln_pkg.sv
// ln_pkg: shared types and constants for the
// LayerNorm statistics stage
package ln_pkg;

  localparam int N_DEF      = 16;
  localparam int FRAC_DEF   = 8;
  localparam int LOG2_D_DEF = 6;

  localparam int VAR_MAX = (1 << (N_DEF - 1)) - 1;

  typedef enum logic [2:0] {
    ACC,
    DRAIN,
    MEAN,
    VAR,
    OUT
  } state_e;

  function automatic int var_max(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

endpackage

// File: rtl/ln_stats_if.sv
// ln_stats_if: sample stream in, mean/var
// result stream out
interface ln_stats_if
  import ln_pkg::*;
#(
  parameter int N = N_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_mean;
  logic [N-1:0] out_var;
  logic         err_len;

  modport master (
    output in_valid, in_data, in_last,
    output out_ready,
    input  in_ready, out_valid,
    input  out_mean, out_var, err_len
  );

  modport slave (
    input  in_valid, in_data, in_last,
    input  out_ready,
    output in_ready, out_valid,
    output out_mean, out_var, err_len
  );

endinterface

// File: rtl/ln_square.sv
// ln_square: registered full-width signed
// square, one cycle latency
module ln_square #(
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic signed [N-1:0]   a,
  output logic signed [2*N-1:0] p
);

  logic signed [2*N-1:0] p_d;
  logic signed [2*N-1:0] p_q;

  // square the new sample, hold otherwise
  always_comb begin
    p_d = p_q;
    if (en) p_d = (2*N)'(a) * (2*N)'(a);
  end

  // product register
  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/ln_stats.sv
// ln_stats: streaming mean / biased variance
// of a D-sample vector, feeding the scale path
module ln_stats
  import ln_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int FRAC_BITS = FRAC_DEF,
  parameter int LOG2_D    = LOG2_D_DEF
) (
  input logic       clk,
  input logic       rst,
  ln_stats_if.slave bus
);

  localparam int SW = N + LOG2_D;
  localparam int PW = 2 * N;
  localparam int QW = PW + LOG2_D;

  localparam logic [LOG2_D:0] D_CNT =
    {1'b1, {LOG2_D{1'b0}}};
  localparam logic [N-1:0] VLIM =
    N'(var_max(N));
  localparam logic [PW-1:0] VLIM_W =
    {{N{1'b0}}, VLIM};

  state_e state_q, state_d;

  logic [SW-1:0]     sum_q, sum_d;
  logic [QW-1:0]     sumsq_q, sumsq_d;
  logic [LOG2_D:0]   cnt_q, cnt_d;
  logic              sqv_q, sqv_d;
  logic              err_q, err_d;
  logic [N-1:0]      mean_q, mean_d;
  logic [PW-1:0]     ex2_q, ex2_d;
  logic [PW-1:0]     msq_q, msq_d;
  logic [N-1:0]      omean_q, omean_d;
  logic [N-1:0]      ovar_q, ovar_d;
  logic              oerr_q, oerr_d;
  logic              ov_q, ov_d;

  logic signed [PW-1:0] sq;
  logic signed [PW-1:0] mean_w;
  logic signed [PW:0]   v;
  logic [PW-1:0]        vpos;
  logic [PW-1:0]        vsh;
  logic [N-1:0]         vsat;
  logic [LOG2_D:0]      cnt_inc;
  logic                 rdy;
  logic                 acc;
  logic                 full;
  logic                 vend;
  logic                 hs;

  assign cnt_inc = cnt_q + 1'b1;
  assign acc  = bus.in_valid && rdy;
  assign full = (cnt_inc == D_CNT);
  assign vend = acc && (bus.in_last || full);
  assign hs   = ov_q && bus.out_ready;

  ln_square #(.N(N)) u_sq (
    .clk (clk),
    .rst (rst),
    .en  (acc),
    .a   (bus.in_data),
    .p   (sq)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  // next state: accumulate, flush, divide,
  // variance, then hold until handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:   if (vend) state_d = DRAIN;
      DRAIN: state_d = MEAN;
      MEAN:  state_d = VAR;
      VAR:   state_d = OUT;
      OUT:   if (hs) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    rdy = (state_q == ACC);
  end

  // variance finish: clamp negative, scale,
  // saturate
  always_comb begin
    v    = $signed({1'b0, ex2_q})
         - $signed({msq_q[PW-1], msq_q});
    vpos = v[PW] ? '0 : v[PW-1:0];
    vsh  = vpos >> FRAC_BITS;
    vsat = (vsh > VLIM_W) ? VLIM : vsh[N-1:0];
  end

  // datapath next values
  always_comb begin
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mean_d  = mean_q;
    ex2_d   = ex2_q;
    msq_d   = msq_q;
    omean_d = omean_q;
    ovar_d  = ovar_q;
    oerr_d  = oerr_q;
    ov_d    = ov_q;
    sqv_d   = acc;
    mean_w  = PW'($signed(mean_q));
    if (acc) begin
      sum_d = sum_q
            + {{LOG2_D{bus.in_data[N-1]}},
               bus.in_data};
      cnt_d = cnt_inc;
    end
    if (vend) err_d = bus.in_last ^ full;
    if (sqv_q) sumsq_d = sumsq_q + {{LOG2_D{1'b0}}, sq};
    if (state_q == MEAN) begin
      mean_d = sum_q[LOG2_D +: N];
      ex2_d  = sumsq_q[LOG2_D +: PW];
    end
    if (state_q == VAR) msq_d = mean_w * mean_w;
    if (state_q == OUT && !ov_q) begin
      omean_d = mean_q;
      ovar_d  = vsat;
      oerr_d  = err_q;
      ov_d    = 1'b1;
    end
    if (hs) begin
      ov_d    = 1'b0;
      sum_d   = '0;
      sumsq_d = '0;
      cnt_d   = '0;
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      sumsq_q <= '0;
      cnt_q   <= '0;
      sqv_q   <= 1'b0;
      err_q   <= 1'b0;
      mean_q  <= '0;
      ex2_q   <= '0;
      msq_q   <= '0;
      omean_q <= '0;
      ovar_q  <= '0;
      oerr_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      cnt_q   <= cnt_d;
      sqv_q   <= sqv_d;
      err_q   <= err_d;
      mean_q  <= mean_d;
      ex2_q   <= ex2_d;
      msq_q   <= msq_d;
      omean_q <= omean_d;
      ovar_q  <= ovar_d;
      oerr_q  <= oerr_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov_q;
  assign bus.out_mean  = omean_q;
  assign bus.out_var   = ovar_q;
  assign bus.err_len   = oerr_q;

endmodule

// File: tb/tb_ln_stats.sv
// tb_ln_stats: directed vectors for ln_stats
// with D = 4
module tb_ln_stats;

  typedef logic [15:0] vec_t [4];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   acc_q[$];

  ln_stats_if #(.N(16)) bus();

  ln_stats #(
    .N(16),
    .FRAC_BITS(8),
    .LOG2_D(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.in_valid && bus.in_ready)
      acc_q.push_back(cyc);
    if (bus.out_valid && bus.out_ready)
      hs_cyc = cyc;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic send_vec(input vec_t s,
                          input int n,
                          input bit last,
                          input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2))
          @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      bus.in_last  = last && (i == n - 1);
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("acc_timeout", 0, 1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_out;
    int t = 0;
    while (!bus.out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_seen",
        {31'b0, bus.out_valid}, 1);
  endtask

  task automatic get_result(
    output logic [15:0] m,
    output logic [15:0] r,
    output logic        e,
    output int          lat);
    wait_out();
    m   = bus.out_mean;
    r   = bus.out_var;
    e   = bus.err_len;
    lat = cyc - acc_q[acc_q.size() - 1];
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  vec_t        vv;
  logic [15:0] m, r;
  logic        e;
  int          lat;
  int          base;
  bit          ok;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_mean", {16'b0, bus.out_mean}, 0);
    chk("rst_var", {16'b0, bus.out_var}, 0);
    chk("rst_err", {31'b0, bus.err_len}, 0);

    vv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_vec(vv, 4, 1'b1, 1'b0);
    get_result(m, r, e, lat);
    chk("basic_mean", {16'b0, m}, 32'h0280);
    chk("basic_var", {16'b0, r}, 32'h0140);
    chk("basic_err", {31'b0, e}, 0);
    chk("basic_lat", lat, 4);

    vv = '{16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00};
    send_vec(vv, 4, 1'b1, 1'b0);
    get_result(m, r, e, lat);
    chk("neg_mean", {16'b0, m}, 32'hFE00);
    chk("neg_var", {16'b0, r}, 32'h0000);

    vv = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    send_vec(vv, 4, 1'b1, 1'b0);
    get_result(m, r, e, lat);
    chk("sat_mean", {16'b0, m}, 32'hFFFF);
    chk("sat_var", {16'b0, r}, 32'h7FFF);
    chk("sat_lat", lat, 4);

    vv = '{16'h0100, 16'h0300, 16'h0000, 16'h0000};
    send_vec(vv, 2, 1'b1, 1'b0);
    get_result(m, r, e, lat);
    chk("short_mean", {16'b0, m}, 32'h0100);
    chk("short_var", {16'b0, r}, 32'h0180);
    chk("short_err", {31'b0, e}, 1);

    vv = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    send_vec(vv, 4, 1'b1, 1'b0);
    get_result(m, r, e, lat);
    chk("full_err", {31'b0, e}, 0);
    chk("full_var", {16'b0, r}, 0);

    vv = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
    send_vec(vv, 4, 1'b0, 1'b0);
    get_result(m, r, e, lat);
    chk("nolast_mean", {16'b0, m}, 32'h0080);
    chk("nolast_err", {31'b0, e}, 1);

    vv = '{16'h0200, 16'h0000, 16'h0400, 16'hFC00};
    send_vec(vv, 4, 1'b1, 1'b1);
    wait_out();
    m  = bus.out_mean;
    r  = bus.out_var;
    e  = bus.err_len;
    chk("bp_mean", {16'b0, m}, 32'h0080);
    chk("bp_var", {16'b0, r}, 32'h08C0);
    chk("bp_err", {31'b0, e}, 0);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_mean !== m || bus.out_var !== r ||
          bus.err_len !== e || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0)
        ok = 1'b0;
    end
    chk("bp_hold", {31'b0, ok}, 1);
    base = acc_q.size();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0100;
    vv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_vec(vv, 4, 1'b1, 1'b0);
    chk("b2b_start", acc_q[base] - hs_cyc, 1);
    get_result(m, r, e, lat);
    chk("b2b_mean", {16'b0, m}, 32'h0280);
    chk("b2b_var", {16'b0, r}, 32'h0140);

    vv = '{16'h7000, 16'h7000, 16'h0000, 16'h0000};
    send_vec(vv, 2, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_mean", {16'b0, bus.out_mean}, 0);
    chk("mrst_ready", {31'b0, bus.in_ready}, 1);
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ok = 1'b0;
    end
    chk("mrst_no_out", {31'b0, ok}, 1);
    vv = '{16'h0100, 16'h0100, 16'h0300, 16'h0300};
    send_vec(vv, 4, 1'b1, 1'b0);
    get_result(m, r, e, lat);
    chk("mrst_v_mean", {16'b0, m}, 32'h0200);
    chk("mrst_v_var", {16'b0, r}, 32'h0100);
    chk("mrst_v_err", {31'b0, e}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

endmodule
